// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin sharing of one fully pipelined multiplier among
// NUM_REQ requesters. A tag pipeline follows each operand pair through the
// multiplier so that the product can be returned to the requester that owns it.
// Optional build macro MULT_ARB_CHECK_EN: responses are qualified by mult_done
// and a sticky err flag records any disagreement between mult_done and the tags.
module mult_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int STAGES  = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*64-1:0]  req_mcand,
  input  logic [NUM_REQ*64-1:0]  req_mplier,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     resp_valid,
  output logic [63:0]            resp_product,
  output logic                   mult_start,
  output logic [63:0]            mult_mcand,
  output logic [63:0]            mult_mplier,
  input  logic [63:0]            mult_product,
  input  logic                   mult_done,
  output logic                   err
);

  localparam int PW = $clog2(NUM_REQ);

  logic [PW-1:0]      ptr_r;
  logic [NUM_REQ-1:0] busy_r;
  logic [STAGES-1:0]  tag_valid_r;
  logic [PW-1:0]      tag_id_r [STAGES];

  logic [NUM_REQ-1:0] eligible_s;
  logic               grant_s;
  logic [PW-1:0]      win_id_s;
  logic [PW-1:0]      cand_s;
  logic [PW-1:0]      ptr_next_s;
  logic               resp_fire_s;
  logic [PW-1:0]      resp_id_s;
  logic [NUM_REQ-1:0] resp_onehot_s;

  // A requester whose response is being presented this cycle is masked as well:
  // its busy bit already dropped on the response edge, but the earliest regrant
  // must be the cycle after resp_valid. No grants are issued while in reset.
  assign eligible_s = reset ? {NUM_REQ{1'b0}} : (req_valid & ~busy_r & ~resp_valid);

  // Round-robin search for the first eligible requester starting at ptr_r
  always_comb begin
    grant_s  = 1'b0;
    win_id_s = '0;
    cand_s   = '0;
    for (int o = 0; o < NUM_REQ; o++) begin
      cand_s = PW'((int'(ptr_r) + o) % NUM_REQ);
      if (!grant_s && eligible_s[cand_s]) begin
        grant_s  = 1'b1;
        win_id_s = cand_s;
      end else begin
        grant_s  = grant_s;
        win_id_s = win_id_s;
      end
    end
  end

  assign ptr_next_s = PW'((int'(win_id_s) + 1) % NUM_REQ);
  assign mult_start = grant_s;

  // One-hot grant and operand steering toward the multiplier
  always_comb begin
    req_ready   = '0;
    mult_mcand  = 64'd0;
    mult_mplier = 64'd0;
    if (grant_s) begin
      req_ready[win_id_s] = 1'b1;
      mult_mcand          = req_mcand[int'(win_id_s)*64 +: 64];
      mult_mplier         = req_mplier[int'(win_id_s)*64 +: 64];
    end else begin
      req_ready   = '0;
      mult_mcand  = 64'd0;
      mult_mplier = 64'd0;
    end
  end

  assign resp_id_s = tag_id_r[STAGES-1];

`ifdef MULT_ARB_CHECK_EN
  assign resp_fire_s = mult_done & tag_valid_r[STAGES-1];

  // Sticky flag: mult_done must coincide exactly with a valid tail tag
  always_ff @(posedge clock) begin
    if (reset) begin
      err <= 1'b0;
    end else begin
      err <= err | (mult_done != tag_valid_r[STAGES-1]);
    end
  end
`else
  logic unused_done_s;

  // The multiplier never stalls, so the tail tag alone identifies a finished product
  assign resp_fire_s   = tag_valid_r[STAGES-1];
  assign unused_done_s = mult_done;
  assign err           = 1'b0;
`endif

  // Decode the tail owner into a one-hot response vector
  always_comb begin
    resp_onehot_s = '0;
    if (resp_fire_s) begin
      resp_onehot_s[resp_id_s] = 1'b1;
    end else begin
      resp_onehot_s = '0;
    end
  end

  // Tag pipeline shifts every cycle in lockstep with the multiplier stages
  always_ff @(posedge clock) begin
    if (reset) begin
      tag_valid_r <= '0;
      for (int i = 0; i < STAGES; i++) begin
        tag_id_r[i] <= '0;
      end
    end else begin
      tag_valid_r <= {tag_valid_r[STAGES-2:0], mult_start};
      tag_id_r[0] <= win_id_s;
      for (int i = 1; i < STAGES; i++) begin
        tag_id_r[i] <= tag_id_r[i-1];
      end
    end
  end

  // Busy bits, round-robin pointer and registered response
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_r       <= '0;
      ptr_r        <= '0;
      resp_valid   <= '0;
      resp_product <= 64'd0;
    end else begin
      busy_r     <= (busy_r | req_ready) & ~resp_onehot_s;
      resp_valid <= resp_onehot_s;
      if (grant_s) begin
        ptr_r <= ptr_next_s;
      end
      if (resp_fire_s) begin
        resp_product <= mult_product;
      end
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed testbench for mult_arbiter with a behavioural 8-stage multiplier.
// Inputs are driven just after the falling edge and outputs sampled 1 time unit later.
module tb_mult_arbiter;

  localparam int N  = 4;
  localparam int ST = 8;

  logic            clock = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*64-1:0] req_mcand;
  logic [N*64-1:0] req_mplier;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    resp_valid;
  logic [63:0]     resp_product;
  logic            mult_start;
  logic [63:0]     mult_mcand;
  logic [63:0]     mult_mplier;
  logic [63:0]     mult_product;
  logic            mult_done;
  logic            err;
  logic            force_done;

  logic [ST-1:0]   mv;
  logic [63:0]     mp [ST];

  int vectors     = 0;
  int miscompares = 0;

  logic [N-1:0] exp_ready;
  logic [N-1:0] exp_resp;
  logic [63:0]  exp_prod;
  logic         exp_err;

  always #5 clock = ~clock;

  mult_arbiter #(.NUM_REQ(N), .STAGES(ST)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_mcand(req_mcand), .req_mplier(req_mplier),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_product(resp_product),
    .mult_start(mult_start), .mult_mcand(mult_mcand), .mult_mplier(mult_mplier),
    .mult_product(mult_product), .mult_done(mult_done), .err(err)
  );

  // Behavioural stand-in for the pipelined multiplier
  always @(posedge clock) begin
    if (reset) begin
      mv <= '0;
      for (int i = 0; i < ST; i++) mp[i] <= 64'd0;
    end else begin
      mv    <= {mv[ST-2:0], mult_start};
      mp[0] <= mult_mcand * mult_mplier;
      for (int i = 1; i < ST; i++) mp[i] <= mp[i-1];
    end
  end

  assign mult_done    = mv[ST-1] | force_done;
  assign mult_product = mp[ST-1];

  task automatic set_op(input int i, input logic [63:0] a, input logic [63:0] b);
    req_mcand[i*64 +: 64]  = a;
    req_mplier[i*64 +: 64] = b;
  endtask

  task automatic test_reset();
    reset = 1'b1; force_done = 1'b0; req_valid = 4'b1111;
    set_op(0, 64'd1, 64'd2); set_op(1, 64'd3, 64'd4);
    set_op(2, 64'd5, 64'd6); set_op(3, 64'd7, 64'd8);
    repeat (3) @(negedge clock);
    #1;
    vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL reset req_ready: got %b expected 0000", req_ready); end
    vectors++; if (mult_start !== 1'b0) begin miscompares++; $display("FAIL reset mult_start: got %b expected 0", mult_start); end
    vectors++; if (mult_mcand !== 64'd0 || mult_mplier !== 64'd0) begin miscompares++; $display("FAIL reset operands: got %h/%h expected 0/0", mult_mcand, mult_mplier); end
    vectors++; if (resp_valid !== 4'b0000) begin miscompares++; $display("FAIL reset resp_valid: got %b expected 0000", resp_valid); end
    vectors++; if (resp_product !== 64'd0) begin miscompares++; $display("FAIL reset resp_product: got %h expected 0", resp_product); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset err: got %b expected 0", err); end
    @(negedge clock);
    reset = 1'b0; req_valid = 4'b0000;
  endtask

  task automatic test_all_four();
    logic [N-1:0] pend;
    logic [63:0]  prods [N];
    set_op(0, 64'd2, 64'd2); set_op(1, 64'd3, 64'd3); set_op(2, 64'd4, 64'd4);
    set_op(3, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF);
    prods[0] = 64'd4; prods[1] = 64'd9; prods[2] = 64'd16; prods[3] = 64'hFFFF_FFFE_0000_0001;
    pend = 4'b1111;
    for (int k = 0; k <= 13; k++) begin
      @(negedge clock);
      req_valid = pend;
      #1;
      exp_ready = (k < 4) ? (4'b0001 << k) : 4'b0000;
      exp_resp  = (k >= 9 && k <= 12) ? (4'b0001 << (k - 9)) : 4'b0000;
      vectors++; if (req_ready !== exp_ready) begin miscompares++; $display("FAIL all4 req_ready cyc %0d: got %b expected %b", k, req_ready, exp_ready); end
      vectors++; if (resp_valid !== exp_resp) begin miscompares++; $display("FAIL all4 resp_valid cyc %0d: got %b expected %b", k, resp_valid, exp_resp); end
      if (k >= 9) begin
        exp_prod = prods[(k > 12) ? 3 : (k - 9)];
        vectors++; if (resp_product !== exp_prod) begin miscompares++; $display("FAIL all4 resp_product cyc %0d: got %h expected %h", k, resp_product, exp_prod); end
      end
      pend = pend & ~exp_ready;
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_single();
    set_op(1, 64'd3, 64'd5);
    for (int k = 0; k <= 10; k++) begin
      @(negedge clock);
      req_valid = (k == 0) ? 4'b0010 : 4'b0000;
      #1;
      exp_ready = (k == 0) ? 4'b0010 : 4'b0000;
      exp_resp  = (k == 9) ? 4'b0010 : 4'b0000;
      vectors++; if (req_ready !== exp_ready) begin miscompares++; $display("FAIL single req_ready cyc %0d: got %b expected %b", k, req_ready, exp_ready); end
      vectors++; if (mult_start !== (k == 0)) begin miscompares++; $display("FAIL single mult_start cyc %0d: got %b expected %b", k, mult_start, (k == 0)); end
      vectors++; if (resp_valid !== exp_resp) begin miscompares++; $display("FAIL single resp_valid cyc %0d: got %b expected %b", k, resp_valid, exp_resp); end
      if (k == 0) begin
        vectors++; if (mult_mcand !== 64'd3 || mult_mplier !== 64'd5) begin miscompares++; $display("FAIL single operands: got %h/%h expected 3/5", mult_mcand, mult_mplier); end
      end
      if (k >= 9) begin
        vectors++; if (resp_product !== 64'd15) begin miscompares++; $display("FAIL single resp_product cyc %0d: got %h expected 15", k, resp_product); end
      end
    end
  endtask

  task automatic test_fairness();
    set_op(3, 64'd7, 64'd6); set_op(0, 64'd10, 64'd11);
    for (int k = 0; k <= 20; k++) begin
      @(negedge clock);
      req_valid = {(k <= 10), 2'b00, (k <= 1)};
      #1;
      exp_ready = (k == 0 || k == 10) ? 4'b1000 : ((k == 1) ? 4'b0001 : 4'b0000);
      exp_resp  = (k == 9 || k == 19) ? 4'b1000 : ((k == 10) ? 4'b0001 : 4'b0000);
      vectors++; if (req_ready !== exp_ready) begin miscompares++; $display("FAIL fair req_ready cyc %0d: got %b expected %b", k, req_ready, exp_ready); end
      vectors++; if (resp_valid !== exp_resp) begin miscompares++; $display("FAIL fair resp_valid cyc %0d: got %b expected %b", k, resp_valid, exp_resp); end
      if (k == 9 || k == 10 || k == 19) begin
        exp_prod = (k == 10) ? 64'd110 : 64'd42;
        vectors++; if (resp_product !== exp_prod) begin miscompares++; $display("FAIL fair resp_product cyc %0d: got %h expected %h", k, resp_product, exp_prod); end
      end
    end
  endtask

  task automatic test_collision();
    set_op(0, 64'd9, 64'd9);
    for (int k = 0; k <= 20; k++) begin
      @(negedge clock);
      if (k == 9) set_op(0, 64'd2, 64'd8);
      req_valid = (k == 0 || k == 9 || k == 10) ? 4'b0001 : 4'b0000;
      #1;
      exp_ready = (k == 0 || k == 10) ? 4'b0001 : 4'b0000;
      exp_resp  = (k == 9 || k == 19) ? 4'b0001 : 4'b0000;
      vectors++; if (req_ready !== exp_ready) begin miscompares++; $display("FAIL collide req_ready cyc %0d: got %b expected %b", k, req_ready, exp_ready); end
      vectors++; if (resp_valid !== exp_resp) begin miscompares++; $display("FAIL collide resp_valid cyc %0d: got %b expected %b", k, resp_valid, exp_resp); end
      if (k == 9 || k == 19) begin
        exp_prod = (k == 9) ? 64'd81 : 64'd16;
        vectors++; if (resp_product !== exp_prod) begin miscompares++; $display("FAIL collide resp_product cyc %0d: got %h expected %h", k, resp_product, exp_prod); end
      end
    end
  endtask

  task automatic test_reset_midflight();
    set_op(0, 64'd100, 64'd100); set_op(1, 64'd200, 64'd3); set_op(2, 64'd5, 64'd5);
    for (int k = 0; k <= 18; k++) begin
      @(negedge clock);
      reset = (k == 5);
      if (k == 7) begin set_op(0, 64'd3, 64'd4); set_op(1, 64'd6, 64'd7); end
      case (k)
        0:       req_valid = 4'b0011;
        1:       req_valid = 4'b0001;
        5, 6:    req_valid = 4'b0100;
        7:       req_valid = 4'b0011;
        8:       req_valid = 4'b0010;
        default: req_valid = 4'b0000;
      endcase
      #1;
      case (k)
        0, 8:    exp_ready = 4'b0010;
        1, 7:    exp_ready = 4'b0001;
        6:       exp_ready = 4'b0100;
        default: exp_ready = 4'b0000;
      endcase
      case (k)
        15:      exp_resp = 4'b0100;
        16:      exp_resp = 4'b0001;
        17:      exp_resp = 4'b0010;
        default: exp_resp = 4'b0000;
      endcase
      vectors++; if (req_ready !== exp_ready) begin miscompares++; $display("FAIL midreset req_ready cyc %0d: got %b expected %b", k, req_ready, exp_ready); end
      vectors++; if (resp_valid !== exp_resp) begin miscompares++; $display("FAIL midreset resp_valid cyc %0d: got %b expected %b", k, resp_valid, exp_resp); end
      if (k == 6 || k == 15 || k == 16 || k == 17) begin
        exp_prod = (k == 6) ? 64'd0 : ((k == 15) ? 64'd25 : ((k == 16) ? 64'd12 : 64'd42));
        vectors++; if (resp_product !== exp_prod) begin miscompares++; $display("FAIL midreset resp_product cyc %0d: got %h expected %h", k, resp_product, exp_prod); end
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_done_force();
`ifdef MULT_ARB_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    for (int k = 0; k <= 4; k++) begin
      @(negedge clock);
      req_valid  = 4'b0000;
      force_done = (k == 0);
      #1;
      vectors++;
      if (err !== ((k == 0) ? 1'b0 : exp_err)) begin miscompares++; $display("FAIL force err cyc %0d: got %b expected %b", k, err, (k == 0) ? 1'b0 : exp_err); end
      vectors++; if (resp_valid !== 4'b0000) begin miscompares++; $display("FAIL force resp_valid cyc %0d: got %b expected 0000", k, resp_valid); end
    end
    force_done = 1'b0;
  endtask

  initial begin
    test_reset();
    test_all_four();
    test_single();
    test_fairness();
    test_collision();
    test_reset_midflight();
    test_done_force();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
